test_seq: RTL

- Tester sequencer directly upstream of the reset-delay generator.
- Issues an active-low reset request (`out_fsm_rst`) to the generator and watches the generator's active-low reset output (`in_dut_rst`) assert and release.
- Then streams NUM_VEC loopback stimulus words to the DUT and checks the returned words in order.
- Reports done, pass/fail, error count and abort status to the host-side control.

---
 rtl/test_seq.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/test_seq.sv
// test_seq: tester sequencer that sits directly upstream of the reset-delay generator.
// It requests a reset, watches the generator's reset output assert and release, then
// streams NUM_VEC loopback stimulus words and checks the returned words in order.
// Optional build macro TEST_SEQ_FIRST_ERR_EN adds first-mismatch index/data outputs.
module test_seq #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned NUM_VEC = 16,
    parameter int unsigned SEED    = 32'h00,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              in_clk,
    input  logic              in_rst,
    input  logic              in_start,
    output logic              out_fsm_rst,
    input  logic              in_dut_rst,
    output logic [DATA_W-1:0] out_stim,
    output logic              out_stim_vld,
    input  logic [DATA_W-1:0] in_resp,
    input  logic              in_resp_vld,
    output logic              out_busy,
    output logic              out_done,
    output logic              out_pass,
    output logic              out_abort,
    output logic [7:0]        out_err_cnt
`ifdef TEST_SEQ_FIRST_ERR_EN
    ,
    output logic [7:0]        out_first_err_idx,
    output logic [DATA_W-1:0] out_first_err_data
`endif
);

    localparam logic [DATA_W-1:0] SeedW   = DATA_W'(SEED);
    localparam logic [7:0]        LastIdx = 8'(NUM_VEC - 1);
    localparam logic [7:0]        NumVec  = 8'(NUM_VEC);
    localparam logic [7:0]        TmoMax  = 8'(TIMEOUT);

    typedef enum logic [2:0] {
        StIdle, StReq, StWaitLo, StWaitHi, StRun, StDrain, StFin
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  tmo_q, tmo_d;
    logic [7:0]  stim_idx_q, stim_idx_d;
    logic [7:0]  resp_idx_q, resp_idx_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic        pass_q, pass_d;
    logic        abort_q, abort_d;
    logic        go_fin, fin_abort;
    logic        run_start;
    logic        checking, resp_acc, resp_bad;
    logic [DATA_W-1:0] resp_exp;

    // Responses count only while running with the DUT out of reset and before NUM_VEC arrive
    always_comb begin
        run_start = (state_q == StIdle) && in_start;
        checking  = ((state_q == StRun) || (state_q == StDrain)) && in_dut_rst;
        resp_exp  = SeedW + DATA_W'(resp_idx_q);
        resp_acc  = checking && in_resp_vld && (resp_idx_q < NumVec);
        resp_bad  = resp_acc && (in_resp != resp_exp);
    end

    // Next-state, counters and result flags
    always_comb begin
        state_d    = state_q;
        tmo_d      = tmo_q;
        stim_idx_d = stim_idx_q;
        resp_idx_d = resp_idx_q;
        err_cnt_d  = err_cnt_q;
        pass_d     = pass_q;
        abort_d    = abort_q;
        go_fin     = 1'b0;
        fin_abort  = 1'b0;

        if (resp_acc) begin
            resp_idx_d = resp_idx_q + 8'd1;
            if (resp_bad && (err_cnt_q != 8'hFF)) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (in_start) begin
                    state_d    = StReq;
                    stim_idx_d = '0;
                    resp_idx_d = '0;
                    err_cnt_d  = '0;
                    pass_d     = 1'b0;
                    abort_d    = 1'b0;
                end
            end
            StReq: state_d = StWaitLo;
            StWaitLo: begin
                if (!in_dut_rst) begin
                    state_d = StWaitHi;
                end else if (tmo_q == TmoMax) begin
                    go_fin    = 1'b1;
                    fin_abort = 1'b1;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            StWaitHi: begin
                if (in_dut_rst) begin
                    state_d = StRun;
                end else if (tmo_q == TmoMax) begin
                    go_fin    = 1'b1;
                    fin_abort = 1'b1;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            StRun: begin
                if (!in_dut_rst) begin
                    go_fin    = 1'b1;
                    fin_abort = 1'b1;
                end else if (stim_idx_q == LastIdx) begin
                    state_d = StDrain;
                end else begin
                    stim_idx_d = stim_idx_q + 8'd1;
                end
            end
            StDrain: begin
                if (!in_dut_rst) begin
                    go_fin    = 1'b1;
                    fin_abort = 1'b1;
                end else if (resp_idx_d == NumVec) begin
                    go_fin = 1'b1;
                end else if (resp_acc) begin
                    tmo_d = '0;
                end else if (tmo_q == TmoMax) begin
                    go_fin    = 1'b1;
                    fin_abort = 1'b1;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Results are settled on FIN entry so they are valid alongside the done pulse
        if (go_fin) begin
            state_d = StFin;
            abort_d = fin_abort;
            pass_d  = !fin_abort && (err_cnt_d == 8'd0);
        end

        // Wait counter restarts on every state entry
        if (state_d != state_q) begin
            tmo_d = '0;
        end
    end

    // State and counter registers
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q    <= StIdle;
            tmo_q      <= '0;
            stim_idx_q <= '0;
            resp_idx_q <= '0;
            err_cnt_q  <= '0;
            pass_q     <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            tmo_q      <= tmo_d;
            stim_idx_q <= stim_idx_d;
            resp_idx_q <= resp_idx_d;
            err_cnt_q  <= err_cnt_d;
            pass_q     <= pass_d;
            abort_q    <= abort_d;
        end
    end

    // Outputs decoded from state; stimulus drops in the same cycle the DUT reset appears
    always_comb begin
        out_fsm_rst  = (state_q != StReq);
        out_busy     = (state_q == StReq) || (state_q == StWaitLo) || (state_q == StWaitHi) ||
                       (state_q == StRun) || (state_q == StDrain);
        out_stim_vld = (state_q == StRun) && in_dut_rst;
        out_stim     = out_stim_vld ? (SeedW + DATA_W'(stim_idx_q)) : '0;
        out_done     = (state_q == StFin);
        out_pass     = pass_q;
        out_abort    = abort_q;
        out_err_cnt  = err_cnt_q;
    end

`ifdef TEST_SEQ_FIRST_ERR_EN
    logic [7:0]        first_idx_q, first_idx_d;
    logic [DATA_W-1:0] first_data_q, first_data_d;

    // Capture only the first mismatch of a run (error count still zero at that point)
    always_comb begin
        first_idx_d  = first_idx_q;
        first_data_d = first_data_q;
        if (run_start) begin
            first_idx_d  = '0;
            first_data_d = '0;
        end else if (resp_bad && (err_cnt_q == 8'd0)) begin
            first_idx_d  = resp_idx_q;
            first_data_d = in_resp;
        end
    end

    // First-mismatch capture registers
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            first_idx_q  <= '0;
            first_data_q <= '0;
        end else begin
            first_idx_q  <= first_idx_d;
            first_data_q <= first_data_d;
        end
    end

    assign out_first_err_idx  = first_idx_q;
    assign out_first_err_data = first_data_q;
`else
    logic unused_run_start;
    assign unused_run_start = run_start;
`endif

endmodule
